// File: rtl/tsal_pkg.sv
// Shared constants and state encoding for the ADC sample averaging path.
package tsal_pkg;

  localparam int ADC_W               = 12;
  localparam int DEF_LOG2_DEPTH      = 3;
  localparam int DEF_TIMEOUT_CYCLES  = 8000;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } tsal_state_t;

endpackage

// File: rtl/adc_sample_filter_if.sv
// Sample stream from the ADC controller in, window mean and status out.
interface adc_sample_filter_if #(
  parameter int DATA_W = 12
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] avg_out;
  logic              avg_valid;
  logic              warm;
  logic              timeout_fault;

  modport master (
    output sample_in, sample_valid,
    input  avg_out, avg_valid, warm, timeout_fault
  );

  modport slave (
    input  sample_in, sample_valid,
    output avg_out, avg_valid, warm, timeout_fault
  );

endinterface

// File: rtl/sample_watchdog.sv
// Idle-cycle watchdog: expired rises TIMEOUT_CYCLES clocks after the last kick
// and stays high until the next kick.
module sample_watchdog #(
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic expired
);

  localparam int            CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] idle_cnt_r;
  logic [CNT_W-1:0] idle_cnt_next_s;
  logic             expired_r;

  // Saturating idle counter; a kick always wins over expiry.
  always_comb begin
    idle_cnt_next_s = idle_cnt_r;
    if (kick) begin
      idle_cnt_next_s = {CNT_W{1'b0}};
    end else if (idle_cnt_r != LIMIT) begin
      idle_cnt_next_s = idle_cnt_r + CNT_W'(1);
    end else begin
      idle_cnt_next_s = idle_cnt_r;
    end
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= {CNT_W{1'b0}};
      expired_r  <= 1'b0;
    end else begin
      idle_cnt_r <= idle_cnt_next_s;
      expired_r  <= (idle_cnt_next_s == LIMIT);
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/adc_sample_filter.sv
// Power-of-two sliding-window mean of ADC conversions, with a stall watchdog
// that flushes the window when samples stop arriving.
module adc_sample_filter
  import tsal_pkg::*;
#(
  parameter int DATA_W         = ADC_W,
  parameter int LOG2_DEPTH     = DEF_LOG2_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                clk,
  input logic                rst_n,
  adc_sample_filter_if.slave bus
);

  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int FILL_W = LOG2_DEPTH + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  tsal_state_t             state_r;
  tsal_state_t             state_next_s;
  logic [DATA_W-1:0]       ring_r [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr_r;
  logic [LOG2_DEPTH-1:0]   wr_ptr_next_s;
  logic [FILL_W-1:0]       fill_r;
  logic [FILL_W-1:0]       fill_next_s;
  logic [SUM_W-1:0]        sum_r;
  logic [SUM_W-1:0]        sum_next_s;
  logic [DATA_W-1:0]       avg_out_r;
  logic [DATA_W-1:0]       avg_out_next_s;
  logic                    avg_valid_r;
  logic                    avg_valid_next_s;
  logic                    warm_r;
  logic [DATA_W-1:0]       old_s;
  logic                    ring_we_s;
  logic                    ring_clr_s;
  logic                    expired_s;

  sample_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (bus.sample_valid),
    .expired (expired_s)
  );

  assign old_s = ring_r[wr_ptr_r];

  // Next-state and datapath updates; an accepted sample takes priority over expiry.
  always_comb begin
    state_next_s     = state_r;
    wr_ptr_next_s    = wr_ptr_r;
    fill_next_s      = fill_r;
    sum_next_s       = sum_r;
    avg_out_next_s   = avg_out_r;
    avg_valid_next_s = 1'b0;
    ring_we_s        = 1'b0;
    ring_clr_s       = 1'b0;
    if (bus.sample_valid) begin
      // Flushed slots read as zero, so FILL and FAULT exit need no special case.
      ring_we_s     = 1'b1;
      sum_next_s    = sum_r + SUM_W'(bus.sample_in) - SUM_W'(old_s);
      wr_ptr_next_s = wr_ptr_r + LOG2_DEPTH'(1);
      if (fill_r != FILL_FULL) begin
        fill_next_s = fill_r + FILL_W'(1);
      end else begin
        fill_next_s = fill_r;
      end
      if (fill_next_s == FILL_FULL) begin
        state_next_s     = RUN;
        avg_valid_next_s = 1'b1;
        avg_out_next_s   = sum_next_s[SUM_W-1:LOG2_DEPTH];
      end else begin
        state_next_s = FILL;
      end
    end else if (expired_s && (state_r != FAULT)) begin
      state_next_s  = FAULT;
      ring_clr_s    = 1'b1;
      sum_next_s    = {SUM_W{1'b0}};
      fill_next_s   = {FILL_W{1'b0}};
      wr_ptr_next_s = {LOG2_DEPTH{1'b0}};
    end else begin
      state_next_s = state_r;
    end
  end

  // State, pointers, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      wr_ptr_r    <= {LOG2_DEPTH{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      sum_r       <= {SUM_W{1'b0}};
      avg_out_r   <= {DATA_W{1'b0}};
      avg_valid_r <= 1'b0;
      warm_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      fill_r      <= fill_next_s;
      sum_r       <= sum_next_s;
      avg_out_r   <= avg_out_next_s;
      avg_valid_r <= avg_valid_next_s;
      warm_r      <= (state_next_s == RUN);
    end
  end

  // Sample ring storage, flushed on reset and on watchdog expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i] <= {DATA_W{1'b0}};
      end
    end else if (ring_clr_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_r[i] <= {DATA_W{1'b0}};
      end
    end else if (ring_we_s) begin
      ring_r[wr_ptr_r] <= bus.sample_in;
    end else begin
      ring_r[wr_ptr_r] <= ring_r[wr_ptr_r];
    end
  end

  assign bus.avg_out       = avg_out_r;
  assign bus.avg_valid     = avg_valid_r;
  assign bus.warm          = warm_r;
  assign bus.timeout_fault = expired_s;

endmodule

// File: tb/tb_adc_sample_filter.sv
// Directed checks of the moving-average filter: fill, step response, spike,
// watchdog fault and recovery, expiry-cycle sample, back-to-back and reset.
module tb_adc_sample_filter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vectors    = 0;
  int   miscompares = 0;

  adc_sample_filter_if #(.DATA_W(12)) bus ();

  adc_sample_filter #(
    .DATA_W         (12),
    .LOG2_DEPTH     (3),
    .TIMEOUT_CYCLES (8000)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [11:0] val);
    bus.sample_in    = val;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  logic [11:0] step_exp [8];

  initial begin
    step_exp[0] = 12'h1FF; step_exp[1] = 12'h3FF; step_exp[2] = 12'h5FF; step_exp[3] = 12'h7FF;
    step_exp[4] = 12'h9FF; step_exp[5] = 12'hBFF; step_exp[6] = 12'hDFF; step_exp[7] = 12'hFFF;
    bus.sample_in    = 12'h000;
    bus.sample_valid = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avg_out", 16'(bus.avg_out), 16'h0000);
    check("rst_avg_valid", 16'(bus.avg_valid), 16'h0000);
    check("rst_warm", 16'(bus.warm), 16'h0000);
    check("rst_fault", 16'(bus.timeout_fault), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Slow fill with 0x800: mean appears only on the eighth sample.
    for (int k = 1; k <= 8; k++) begin
      pulse(12'h800);
      check("fill_valid", 16'(bus.avg_valid), (k == 8) ? 16'h0001 : 16'h0000);
      if (k < 8) repeat (1279) tick();
    end
    check("fill_avg", 16'(bus.avg_out), 16'h0800);
    check("fill_warm", 16'(bus.warm), 16'h0001);
    tick();
    check("fill_single_pulse", 16'(bus.avg_valid), 16'h0000);

    // Zero window, then a full-scale step.
    for (int k = 0; k < 8; k++) pulse(12'h000);
    check("zero_avg", 16'(bus.avg_out), 16'h0000);
    for (int k = 0; k < 8; k++) begin
      pulse(12'hFFF);
      check("step_valid", 16'(bus.avg_valid), 16'h0001);
      check("step_avg", 16'(bus.avg_out), 16'(step_exp[k]));
    end

    // Spike: 7*0x100 + 0xF00 = 0x1600, mean 0x2C0.
    for (int k = 0; k < 8; k++) pulse(12'h100);
    check("base_avg", 16'(bus.avg_out), 16'h0100);
    pulse(12'hF00);
    check("spike_avg", 16'(bus.avg_out), 16'h02C0);
    for (int k = 0; k < 7; k++) pulse(12'h100);
    check("spike_still_in", 16'(bus.avg_out), 16'h02C0);
    pulse(12'h100);
    check("spike_flushed", 16'(bus.avg_out), 16'h0100);

    // Stall: fault on exactly the 8000th idle edge.
    repeat (7999) tick();
    check("pre_expiry_fault", 16'(bus.timeout_fault), 16'h0000);
    tick();
    check("expiry_fault", 16'(bus.timeout_fault), 16'h0001);
    tick();
    check("fault_warm", 16'(bus.warm), 16'h0000);
    check("fault_avg_held", 16'(bus.avg_out), 16'h0100);
    for (int k = 1; k <= 8; k++) begin
      pulse(12'h400);
      if (k == 1) check("recover_fault", 16'(bus.timeout_fault), 16'h0000);
      check("refill_valid", 16'(bus.avg_valid), (k == 8) ? 16'h0001 : 16'h0000);
    end
    check("refill_avg", 16'(bus.avg_out), 16'h0400);
    check("refill_warm", 16'(bus.warm), 16'h0001);

    // Sample on the would-be expiry edge: 7*0x400 + 0xC00 = 0x2800, mean 0x500.
    repeat (7999) tick();
    pulse(12'hC00);
    check("race_fault", 16'(bus.timeout_fault), 16'h0000);
    check("race_valid", 16'(bus.avg_valid), 16'h0001);
    check("race_avg", 16'(bus.avg_out), 16'h0500);
    repeat (10) tick();
    check("race_no_late_fault", 16'(bus.timeout_fault), 16'h0000);

    // Back-to-back burst in RUN.
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'h200;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("burst_valid", 16'(bus.avg_valid), 16'h0001);
    end
    bus.sample_valid = 1'b0;
    check("burst_avg", 16'(bus.avg_out), 16'h0200);
    tick();
    check("burst_end_valid", 16'(bus.avg_valid), 16'h0000);

    // Reset mid-burst.
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'h300;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_avg", 16'(bus.avg_out), 16'h0000);
    check("async_rst_valid", 16'(bus.avg_valid), 16'h0000);
    check("async_rst_warm", 16'(bus.warm), 16'h0000);
    check("async_rst_fault", 16'(bus.timeout_fault), 16'h0000);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.sample_valid = 1'b1;
    bus.sample_in    = 12'h600;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("post_rst_valid", 16'(bus.avg_valid), (k == 8) ? 16'h0001 : 16'h0000);
    end
    bus.sample_valid = 1'b0;
    check("post_rst_avg", 16'(bus.avg_out), 16'h0600);
    check("post_rst_warm", 16'(bus.warm), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
